// File: rtl/sbitstream_decoder.sv
// ---------------------------------------------------------------------------
// sbitstream_decoder
//
// Receive side of the stochastic-bitstream path. A signed bitstream arrives as
// a pos/neg channel pair, one sample per accepted cycle. The block counts
// (pos - neg) over a window of 2^WINDOW_LOG2 accepted samples. Each completed
// window's signed count is presented on a valid/ready output register. The
// represented value is out_value / 2^WINDOW_LOG2.
//
// Parameters
//   WINDOW_LOG2  window length is 2^WINDOW_LOG2 accepted samples (1..30)
//   OUT_WIDTH    signed result width, fixed at WINDOW_LOG2+2
//
// Ports
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   clr        in   1          sync clear of window accumulation; output kept
//   in_valid   in   1          sample present on in_pos/in_neg
//   in_pos     in   1          positive-channel bit
//   in_neg     in   1          negative-channel bit
//   in_ready   out  1          sample accepted when in_valid & in_ready
//   out_valid  out  1          out_value holds a completed window result
//   out_ready  in   1          consumer takes out_value when out_valid & out_ready
//   out_value  out  OUT_WIDTH  signed sum(pos - neg) over the window
// ---------------------------------------------------------------------------
module sbitstream_decoder #(
    parameter  int WINDOW_LOG2 = 8,
    localparam int OUT_WIDTH   = WINDOW_LOG2 + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic                 in_pos,
    input  logic                 in_neg,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_value
);

    localparam logic [WINDOW_LOG2-1:0] LAST_IDX = '1;
    localparam logic [WINDOW_LOG2-1:0] CNT_ONE  = WINDOW_LOG2'(1);

    logic [WINDOW_LOG2-1:0]      smp_cnt;
    logic signed [OUT_WIDTH-1:0] acc;
    logic signed [OUT_WIDTH-1:0] delta;
    logic signed [OUT_WIDTH-1:0] acc_next;
    logic                        last_sample;
    logic                        accept;

    // The final sample of a window is the only one that writes the output
    // register, so it is the only one that has to wait for the consumer.
    // Every other sample flows freely, and no unread result is overwritten.
    assign last_sample = (smp_cnt == LAST_IDX);
    assign in_ready    = !(last_sample && out_valid && !out_ready);
    assign accept      = in_valid && in_ready;

    // Map the pos/neg pair onto a signed step. A pair with both bits set
    // cancels to zero, the same as a pair with both bits clear.
    always_comb begin
        delta = '0;
        if (in_pos && !in_neg) begin
            delta = OUT_WIDTH'(1);
        end else if (in_neg && !in_pos) begin
            delta = '1;
        end
        acc_next = acc + delta;
    end

    // Window accumulation and the output register share one process.
    // A consumed result clears out_valid first. A window ending on the same
    // edge then sets it again, so back-to-back results have no bubble.
    // clr wins over a window end: the sample presented with clr is dropped
    // and no result is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (clr) begin
                acc     <= '0;
                smp_cnt <= '0;
            end else if (accept) begin
                if (last_sample) begin
                    out_value <= acc_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    smp_cnt   <= '0;
                end else begin
                    acc     <= acc_next;
                    smp_cnt <= smp_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbitstream_decoder.sv
// ---------------------------------------------------------------------------
// tb_sbitstream_decoder
//
// Directed bench for sbitstream_decoder with an 8-sample window.
// A table of per-cycle vectors covers single windows and back-to-back
// windows. Hand-written sequences cover backpressure, input gaps, clr and
// reset in the middle of a window.
// ---------------------------------------------------------------------------
module tb_sbitstream_decoder;

    localparam int W    = 3;
    localparam int OW   = W + 2;
    localparam int WLEN = 1 << W;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          inValid;
    logic          inPos;
    logic          inNeg;
    logic          inReady;
    logic          outValid;
    logic          outReady;
    logic [OW-1:0] outValue;

    int checks;
    int errors;

    typedef struct {
        logic inValid;
        logic inPos;
        logic inNeg;
        logic outReady;
        logic clr;
        logic expReady;
        logic expValid;
        int   expValue;
    } vecT;

    vecT vecQ[$];

    sbitstream_decoder #(.WINDOW_LOG2(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (inValid),
        .in_pos    (inPos),
        .in_neg    (inNeg),
        .in_ready  (inReady),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_value (outValue)
    );

    // Free-running clock. The DUT acts on the rising edge. The bench drives
    // and samples just after the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change at the falling edge. The #1 lets the combinational
    // in_ready settle before any check.
    task automatic applyStimulus(input logic v, input logic p, input logic n,
                                 input logic ordy, input logic c);
        @(negedge clk);
        inValid  = v;
        inPos    = p;
        inNeg    = n;
        outReady = ordy;
        clr      = c;
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic v, input logic p, input logic n, input logic ordy,
                          input logic c, input logic er, input logic ev, input int eval);
        vecT t;
        t.inValid  = v;
        t.inPos    = p;
        t.inNeg    = n;
        t.outReady = ordy;
        t.clr      = c;
        t.expReady = er;
        t.expValid = ev;
        t.expValue = eval;
        vecQ.push_back(t);
    endtask

    // Checks the registered outputs, which reflect the edges already taken.
    task automatic checkOut(input string name, input logic ev, input int eval);
        checkOutput({name, "_valid"}, int'(outValid), int'(ev));
        checkOutput({name, "_value"}, int'($signed(outValue)), eval);
    endtask

    logic [19:0] gapPat;
    logic [7:0]  posPat;
    logic [7:0]  bothPat;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        inValid  = 1'b0;
        inPos    = 1'b0;
        inNeg    = 1'b0;
        outReady = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_ready", int'(inReady), 1);
        checkOut("reset", 1'b0, 0);

        // Table: a window of +1 samples, then -1 samples back-to-back,
        // then alternating +1/-1 samples, all with the consumer ready.
        for (int i = 0; i < 8; i++) addVec(1, 1, 0, 1, 0, 1, 0, 0);
        addVec(1, 0, 1, 1, 0, 1, 1, 8);
        for (int i = 9; i < 16; i++) addVec(1, 0, 1, 1, 0, 1, 0, 8);
        addVec(1, 1, 0, 1, 0, 1, 1, -8);
        for (int i = 17; i < 24; i++) addVec(1, (i % 2 == 0), (i % 2 != 0), 1, 0, 1, 0, -8);
        addVec(0, 0, 0, 1, 0, 1, 1, 0);
        addVec(0, 0, 0, 1, 0, 1, 0, 0);

        foreach (vecQ[i]) begin
            applyStimulus(vecQ[i].inValid, vecQ[i].inPos, vecQ[i].inNeg,
                          vecQ[i].outReady, vecQ[i].clr);
            checkOutput($sformatf("vec%0d_ready", i), int'(inReady), int'(vecQ[i].expReady));
            checkOut($sformatf("vec%0d", i), vecQ[i].expValid, vecQ[i].expValue);
        end

        // Backpressure: the consumer is held off for 16 +1 samples.
        for (int i = 0; i < WLEN; i++) applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < WLEN - 1; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            checkOutput("bp_ready", int'(inReady), 1);
            checkOut("bp_held", 1'b1, 8);
        end
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("bp_stall_ready", int'(inReady), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("bp_stall2_ready", int'(inReady), 0);
        checkOut("bp_stall", 1'b1, 8);
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("bp_release_ready", int'(inReady), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOut("bp_next", 1'b1, 8);
        applyStimulus(0, 0, 0, 1, 0);
        checkOut("bp_drained", 1'b0, 8);

        // Input gaps: 8 samples spread over 20 cycles, the last in cycle 19.
        gapPat = 20'b1000_1001_0010_0101_0011;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(gapPat[i], 1, 0, 1, 0);
            checkOut("gap_pending", 1'b0, 8);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOut("gap_result", 1'b1, 8);

        // clr: a held result of -2, then 5 samples, then a clr that also
        // presents a sample. The held result must survive. The next full
        // window then counts only 3 pos samples.
        for (int i = 0; i < WLEN; i++) applyStimulus(1, (i >= 2), 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOut("clr_held", 1'b1, -2);
        posPat  = 8'b0101_0010;
        bothPat = 8'b0000_1001;
        for (int i = 0; i < WLEN; i++) begin
            applyStimulus(1, posPat[i] | bothPat[i], bothPat[i], 1, 0);
            checkOut("clr_window", 1'b0, -2);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOut("clr_result", 1'b1, 3);

        // clr arriving with the last sample of a window: no result appears.
        // The count restarts from zero.
        for (int i = 0; i < WLEN - 1; i++) applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOut("clr_prio", 1'b0, 3);
        for (int i = 0; i < WLEN; i++) applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOut("clr_restart", 1'b1, -8);
        applyStimulus(0, 0, 0, 1, 0);

        // Reset with an unread result held and 4 samples into the next window.
        for (int i = 0; i < WLEN; i++) applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOut("prerst", 1'b1, 8);
        #2;
        rst = 1'b1;
        #1;
        checkOut("async_rst", 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_ready", int'(inReady), 1);
        for (int i = 0; i < WLEN; i++) begin
            applyStimulus(1, (i < 6), (i >= 6), 1, 0);
            checkOut("postrst_window", 1'b0, 0);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOut("postrst_result", 1'b1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
